// File: rtl/mac_pkg.sv
// mac_pkg: constants shared by the MAC datapath and the MAC control unit.
//   MAC_DATA_W / MAC_ACC_W : default operand and accumulator widths
//   OUT_DEPTH              : depth of the result buffer in mac_dp
//   SEL1_IDLE / SEL2_IDLE  : idle control values (restart, no push)
package mac_pkg;
    localparam int   MAC_DATA_W = 8;
    localparam int   MAC_ACC_W  = 20;
    localparam int   OUT_DEPTH  = 2;
    localparam logic SEL1_IDLE  = 1'b1;
    localparam logic SEL2_IDLE  = 1'b1;
endpackage

// File: rtl/mac_out_fifo.sv
// mac_out_fifo: 2-entry result buffer for mac_dp.
//   clk, rst     : clock, asynchronous active-high reset
//   push_i       : write push_data_i (accepted when not full, or when a pop
//                  happens in the same cycle)
//   pop_i        : remove the head (ignored when empty)
//   head_o       : head entry, 0 when empty
//   count_o      : occupancy 0..2
//   full_o       : two entries held
//   empty_o      : no entries held
module mac_out_fifo
    import mac_pkg::*;
#(
    parameter int W = MAC_ACC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o,
    output logic         full_o,
    output logic         empty_o
);

    // Entry 0 is always the head; a pop shifts entry 1 down.
    logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]   count_q, count_d;
    logic         do_pop, do_push;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'(OUT_DEPTH));
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : e0_q;

    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        case ({do_push, do_pop})
            2'b01: begin
                e0_d    = e1_q;
                count_d = count_q - 2'd1;
            end
            2'b10: begin
                if (count_q == 2'd0) e0_d = push_data_i;
                else                 e1_d = push_data_i;
                count_d = count_q + 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the new entry lands behind whatever survives the pop.
                if (count_q == 2'd1) begin
                    e0_d = push_data_i;
                end else begin
                    e0_d = e1_q;
                    e1_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= '0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mac_dp.sv
// mac_dp: pipelined signed multiply-accumulate datapath.
//   clk, rst      : clock, asynchronous active-high reset
//   sel1          : 1 = term restarts the sum, 0 = term adds to it
//   sel2          : 0 = last term of window (push result), 1 = not last
//   in_a, in_b    : signed operands, one term per cycle, no stall
//   out_data      : head of the result buffer, 0 when empty
//   out_valid     : buffer non-empty
//   out_ready     : downstream takes the head this cycle
//   out_count     : buffer occupancy 0..2
//   overflow      : sticky, a result was dropped on a full buffer
// Pipeline: operands registered, product registered, then accumulate/push.
module mac_dp
    import mac_pkg::*;
#(
    parameter int DATA_W = MAC_DATA_W,
    parameter int ACC_W  = MAC_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel1,
    input  logic              sel2,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_count,
    output logic              overflow
);

    logic signed [DATA_W-1:0]   a_q, b_q;
    logic                       sel1_s1_q, sel2_s1_q;
    logic signed [2*DATA_W-1:0] prod_q;
    logic                       sel1_s2_q, sel2_s2_q;
    logic [ACC_W-1:0]           acc_q, acc_d;
    logic                       overflow_q, overflow_d;
    logic                       push, fifo_full, fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            sel1_s1_q <= SEL1_IDLE;
            sel2_s1_q <= SEL2_IDLE;
            prod_q    <= '0;
            sel1_s2_q <= SEL1_IDLE;
            sel2_s2_q <= SEL2_IDLE;
            acc_q     <= '0;
        end else begin
            a_q       <= in_a;
            b_q       <= in_b;
            sel1_s1_q <= sel1;
            sel2_s1_q <= sel2;
            prod_q    <= (2*DATA_W)'(a_q) * (2*DATA_W)'(b_q);
            sel1_s2_q <= sel1_s1_q;
            sel2_s2_q <= sel2_s1_q;
            acc_q     <= acc_d;
        end
    end

    // Sign-extended product; the sum wraps modulo 2^ACC_W.
    always_comb begin
        acc_d = (sel1_s2_q ? '0 : acc_q) + ACC_W'(prod_q);
    end

    assign push = !sel2_s2_q;

    // A push onto a full buffer is dropped unless the head leaves this cycle
    // (out_ready alone suffices here: full implies out_valid).
    always_comb begin
        overflow_d = overflow_q;
        if (push && fifo_full && !out_ready) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) overflow_q <= 1'b0;
        else     overflow_q <= overflow_d;
    end

    assign overflow  = overflow_q;
    assign out_valid = !fifo_empty;

    mac_out_fifo #(
        .W(ACC_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_data_i(acc_d),
        .pop_i      (out_ready),
        .head_o     (out_data),
        .count_o    (out_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

endmodule
